// File: rtl/vram_arb.sv
// VRAM arbiter: shares one VRAM port between the display line fetcher and a
// pixel writer. The fetcher has priority; once a line request is taken the
// writer is stalled until the whole line is in the line buffer.
//
// Timeline for a request seen in cycle N:
//   N+1 .. N+LINE_LEN    FETCH: one VRAM read per cycle
//   N+2 .. N+LINE_LEN+1  line-buffer writes (read data arrives a cycle late)
//   N+LINE_LEN+1         LAST: final line-buffer write, o_line_done pulse

module vram_arb #(
   parameter int unsigned ADDR_W   = 15,
   parameter int unsigned DATA_W   = 12,
   parameter int unsigned LINE_LEN = 160,
   parameter int unsigned LB_W     = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_line_req,
   input  logic [ADDR_W-1:0] i_line_base,
   input  logic              i_wr_valid,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_ready,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic              o_ram_we,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata,
   output logic              o_lb_we,
   output logic [LB_W-1:0]   o_lb_addr,
   output logic [DATA_W-1:0] o_lb_wdata,
   output logic              o_line_done,
   output logic              o_busy,
   output logic              o_ovf
);

   // The index must reach LINE_LEN-1 and also cover every line-buffer address.
   localparam int unsigned IDX_W = (ADDR_W > LB_W) ? ADDR_W : LB_W;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LINE_LEN - 1);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StLast  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic                ovf_q, ovf_d;
   logic [ADDR_W-1:0]   ram_addr_q;
   logic                lb_we_q;
   logic [LB_W-1:0]     lb_addr_q;
   logic [1:0]          rst_sync_q;

   logic                run;
   logic                wr_ready;
   logic                ram_we;
   logic [ADDR_W-1:0]   ram_addr;
   logic                fetch_rd;
   logic                line_done;
   logic                busy;

   // Reset release synchronizer: assertion is immediate, release takes two edges.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign run = rst_sync_q[1];

   // State, index, latched base and sticky overflow registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         base_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         base_q  <= base_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state logic and the combinational VRAM port mux.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      base_d    = base_q;
      ovf_d     = ovf_q;
      wr_ready  = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = ram_addr_q;
      fetch_rd  = 1'b0;
      line_done = 1'b0;
      busy      = 1'b0;

      case (state_q)
         StIdle: begin
            // Nothing is accepted until the reset synchronizer has released.
            if (run) begin
               if (i_line_req) begin
                  state_d = StFetch;
                  base_d  = i_line_base;
                  idx_d   = '0;
               end else begin
                  wr_ready = 1'b1;
                  if (i_wr_valid) begin
                     ram_we   = 1'b1;
                     ram_addr = i_wr_addr;
                  end
               end
            end
         end

         StFetch: begin
            busy     = 1'b1;
            fetch_rd = 1'b1;
            // Natural ADDR_W-bit overflow gives the required wrap to 0.
            ram_addr = base_q + idx_q[ADDR_W-1:0];
            idx_d    = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
               state_d = StLast;
            end
            if (i_line_req) begin
               ovf_d = 1'b1;
            end
         end

         StLast: begin
            busy      = 1'b1;
            line_done = 1'b1;
            state_d   = StIdle;
            if (i_line_req) begin
               ovf_d = 1'b1;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // VRAM address is held between accesses so the bus stays quiet when idle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ram_addr_q <= '0;
      end else begin
         ram_addr_q <= ram_addr;
      end
   end

   // Line-buffer write trails each VRAM read by one cycle to match RAM latency.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lb_we_q   <= 1'b0;
         lb_addr_q <= '0;
      end else begin
         lb_we_q <= fetch_rd;
         if (fetch_rd) begin
            lb_addr_q <= idx_q[LB_W-1:0];
         end
      end
   end

   assign o_wr_ready  = wr_ready;
   assign o_ram_we    = ram_we;
   assign o_ram_addr  = ram_addr;
   assign o_ram_wdata = i_wr_data;
   assign o_lb_we     = lb_we_q;
   assign o_lb_addr   = lb_addr_q;
   assign o_lb_wdata  = i_ram_rdata;
   assign o_line_done = line_done;
   assign o_busy      = busy;
   assign o_ovf       = ovf_q;

endmodule

// File: tb/tb_vram_arb.sv
// Bench for vram_arb with LINE_LEN = 4. A single process drives inputs on the
// falling edge, checks outputs against a timeline model of the arbiter, and
// plays the VRAM and line buffer at the rising edge.

module tb_vram_arb;

   localparam int unsigned AW  = 15;
   localparam int unsigned DW  = 12;
   localparam int unsigned L   = 4;
   localparam int unsigned LBW = 8;
   localparam int          NONE = -1000000;

   logic          clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_line_req = 1'b0;
   logic [AW-1:0] i_line_base = '0;
   logic          i_wr_valid = 1'b0;
   logic [AW-1:0] i_wr_addr = '0;
   logic [DW-1:0] i_wr_data = '0;
   logic          o_wr_ready;
   logic [AW-1:0] o_ram_addr;
   logic          o_ram_we;
   logic [DW-1:0] o_ram_wdata;
   logic [DW-1:0] i_ram_rdata = '0;
   logic          o_lb_we;
   logic [LBW-1:0] o_lb_addr;
   logic [DW-1:0] o_lb_wdata;
   logic          o_line_done;
   logic          o_busy;
   logic          o_ovf;

   always #5 clk = ~clk;

   vram_arb #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .LINE_LEN (L),
      .LB_W     (LBW)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (i_rst_n),
      .i_line_req  (i_line_req),
      .i_line_base (i_line_base),
      .i_wr_valid  (i_wr_valid),
      .i_wr_addr   (i_wr_addr),
      .i_wr_data   (i_wr_data),
      .o_wr_ready  (o_wr_ready),
      .o_ram_addr  (o_ram_addr),
      .o_ram_we    (o_ram_we),
      .o_ram_wdata (o_ram_wdata),
      .i_ram_rdata (i_ram_rdata),
      .o_lb_we     (o_lb_we),
      .o_lb_addr   (o_lb_addr),
      .o_lb_wdata  (o_lb_wdata),
      .o_line_done (o_line_done),
      .o_busy      (o_busy),
      .o_ovf       (o_ovf)
   );

   typedef struct {
      logic          req;
      logic [AW-1:0] base;
      logic          wv;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic          e_ready;
      logic          e_we;
      logic [AW-1:0] e_addr;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] mem       [0:(1<<AW)-1];   // VRAM as the DUT sees it
   logic [DW-1:0] model_mem [0:(1<<AW)-1];   // VRAM as the model expects it
   logic [DW-1:0] lb        [0:(1<<LBW)-1];  // captured line buffer

   // Model: a line accepted at cycle fstart owns the bus for the next L+1 cycles.
   int            cyc = 0;
   int            fstart = NONE;
   logic [AW-1:0] fbase = '0;
   logic [AW-1:0] last_addr = '0;
   logic [LBW-1:0] last_lb = '0;
   bit            ovf_m = 1'b0;
   int            run_cnt = 0;

   int            n_lbwe = 0;
   int            n_done = 0;
   logic [AW-1:0] smp_addr;
   logic          smp_we;
   logic          smp_ready;
   logic          smp_ovf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic cycle(input logic rst_v, input logic req, input logic [AW-1:0] base,
                        input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        output bit acc);
      int             rel;
      bit             e_run, e_busy, e_rd, e_lbwe, e_done, e_ready, e_wr;
      logic [AW-1:0]  e_addr;
      logic [LBW-1:0] e_lba;
      logic [DW-1:0]  e_lbd;
      logic [AW-1:0]  s_addr;
      logic           s_we;
      logic [DW-1:0]  s_wd;
      logic           s_lbwe;
      logic [LBW-1:0] s_lba;
      logic [DW-1:0]  s_lbd;

      @(negedge clk);
      i_rst_n     = rst_v;
      i_line_req  = req;
      i_line_base = base;
      i_wr_valid  = wv;
      i_wr_addr   = wa;
      i_wr_data   = wd;
      #1;

      if (!rst_v) begin
         fstart    = NONE;
         ovf_m     = 1'b0;
         run_cnt   = 0;
         last_addr = '0;
         last_lb   = '0;
      end
      rel     = cyc - fstart;
      e_run   = rst_v && (run_cnt >= 2);
      e_busy  = rst_v && rel >= 1 && rel <= int'(L) + 1;
      e_rd    = rst_v && rel >= 1 && rel <= int'(L);
      e_lbwe  = rst_v && rel >= 2 && rel <= int'(L) + 1;
      e_done  = rst_v && rel == int'(L) + 1;
      e_ready = e_run && !e_busy && !req;
      e_wr    = e_ready && wv;
      e_addr  = e_rd ? fbase + AW'(rel - 1) : (e_wr ? wa : last_addr);
      e_lba   = e_lbwe ? LBW'(rel - 2) : last_lb;
      e_lbd   = model_mem[fbase + AW'(rel - 2)];

      chk("busy", 32'(o_busy), 32'(e_busy));
      chk("wr_ready", 32'(o_wr_ready), 32'(e_ready));
      chk("ram_we", 32'(o_ram_we), 32'(e_wr));
      chk("ram_addr", 32'(o_ram_addr), 32'(e_addr));
      chk("lb_we", 32'(o_lb_we), 32'(e_lbwe));
      chk("lb_addr", 32'(o_lb_addr), 32'(e_lba));
      chk("line_done", 32'(o_line_done), 32'(e_done));
      chk("ovf", 32'(o_ovf), 32'(ovf_m));
      if (e_wr) chk("ram_wdata", 32'(o_ram_wdata), 32'(wd));
      if (e_lbwe) chk("lb_wdata", 32'(o_lb_wdata), 32'(e_lbd));

      s_addr = o_ram_addr;
      s_we   = o_ram_we;
      s_wd   = o_ram_wdata;
      s_lbwe = o_lb_we;
      s_lba  = o_lb_addr;
      s_lbd  = o_lb_wdata;
      smp_addr  = o_ram_addr;
      smp_we    = o_ram_we;
      smp_ready = o_wr_ready;
      smp_ovf   = o_ovf;
      if (o_lb_we === 1'b1) n_lbwe++;
      if (o_line_done === 1'b1) n_done++;
      acc = e_wr;

      @(posedge clk);
      #1;
      // RAM: read-before-write, data visible one cycle after the address.
      i_ram_rdata = mem[s_addr];
      if (s_we === 1'b1) mem[s_addr] = s_wd;
      if (s_lbwe === 1'b1) lb[s_lba] = s_lbd;

      if (rst_v) begin
         if (e_run && req) begin
            if (e_busy) begin
               ovf_m = 1'b1;
            end else begin
               fstart = cyc;
               fbase  = base;
            end
         end
         if (e_wr) model_mem[wa] = wd;
         last_addr = e_addr;
         if (e_lbwe) last_lb = e_lba;
         if (run_cnt < 2) run_cnt++;
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, acc);
   endtask

   task automatic line(input logic [AW-1:0] base);
      bit acc;
      cycle(1'b1, 1'b1, base, 1'b0, '0, '0, acc);
   endtask

   task automatic chk_lb(input string name, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                         input logic [DW-1:0] e2, input logic [DW-1:0] e3);
      chk(name, 32'(lb[8'd0]), 32'(e0));
      chk(name, 32'(lb[8'd1]), 32'(e1));
      chk(name, 32'(lb[8'd2]), 32'(e2));
      chk(name, 32'(lb[8'd3]), 32'(e3));
   endtask

   initial begin
      vec_t          tbl [8];
      logic [AW-1:0] wrap_exp [4];
      bit            acc;
      bit            hold;
      logic [AW-1:0] ha;
      logic [DW-1:0] hd;
      int            k;
      int            d_we, d_done, n_acc, rst_left;
      logic          rst_v;

      tbl[0] = '{1'b0, 15'h0000, 1'b1, 15'h0100, 12'h123, 1'b1, 1'b1, 15'h0100};
      tbl[1] = '{1'b0, 15'h0000, 1'b0, 15'h0000, 12'h000, 1'b1, 1'b0, 15'h0100};
      tbl[2] = '{1'b1, 15'h0200, 1'b1, 15'h0300, 12'h456, 1'b0, 1'b0, 15'h0100};
      tbl[3] = '{1'b0, 15'h0000, 1'b1, 15'h7FFF, 12'hFFF, 1'b1, 1'b1, 15'h7FFF};
      tbl[4] = '{1'b1, 15'h7FFE, 1'b0, 15'h0000, 12'h000, 1'b0, 1'b0, 15'h7FFF};
      tbl[5] = '{1'b0, 15'h0000, 1'b0, 15'h0000, 12'h000, 1'b1, 1'b0, 15'h0001};
      tbl[6] = '{1'b0, 15'h0000, 1'b1, 15'h0000, 12'h5A5, 1'b1, 1'b1, 15'h0000};
      tbl[7] = '{1'b0, 15'h0000, 1'b0, 15'h0000, 12'h000, 1'b1, 1'b0, 15'h0000};
      wrap_exp[0] = 15'h7FFE;
      wrap_exp[1] = 15'h7FFF;
      wrap_exp[2] = 15'h0000;
      wrap_exp[3] = 15'h0001;

      for (int a = 0; a < (1 << AW); a++) begin
         mem[AW'(a)]       = DW'(a);
         model_mem[AW'(a)] = DW'(a);
      end
      for (int a = 0; a < (1 << LBW); a++) lb[LBW'(a)] = '0;

      // Reset held with a writer waiting: nothing may be accepted.
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b1, 15'h0050, 12'h111, acc);
      k = 0;
      acc = 1'b0;
      while (!acc && k < 6) begin
         cycle(1'b1, 1'b0, '0, 1'b1, 15'h0050, 12'h111, acc);
         if (!acc) k++;
      end
      chk("rst_release_lat", 32'(k), 32'd2);
      idle(2);

      // Basic fetch.
      d_we = n_lbwe; d_done = n_done;
      line(15'h0010);
      idle(6);
      chk("basic_lbwe_cnt", 32'(n_lbwe - d_we), 32'd4);
      chk("basic_done_cnt", 32'(n_done - d_done), 32'd1);
      chk_lb("basic_lb", 12'h010, 12'h011, 12'h012, 12'h013);

      // Address wrap.
      line(15'h7FFE);
      for (int i = 0; i < 4; i++) begin
         idle(1);
         chk("wrap_addr", 32'(smp_addr), 32'(wrap_exp[2'(i)]));
      end
      idle(3);
      chk_lb("wrap_lb", 12'hFFE, 12'hFFF, 12'h000, 12'h001);

      // Line request and write in the same cycle: line wins, write waits.
      cycle(1'b1, 1'b1, 15'h0040, 1'b1, 15'h0020, 12'hABC, acc);
      chk("collide_first", 32'(acc), 32'd0);
      k = 1;
      acc = 1'b0;
      while (!acc && k <= 20) begin
         cycle(1'b1, 1'b0, '0, 1'b1, 15'h0020, 12'hABC, acc);
         if (!acc) k++;
      end
      chk("collide_lat", 32'(k), 32'(L + 2));
      idle(1);
      chk("collide_mem", 32'(mem[15'h0020]), 32'h0ABC);

      // Second request during a fetch.
      d_we = n_lbwe; d_done = n_done;
      line(15'h0100);
      idle(1);
      line(15'h0300);
      idle(6);
      chk("ovf_lbwe_cnt", 32'(n_lbwe - d_we), 32'd4);
      chk("ovf_done_cnt", 32'(n_done - d_done), 32'd1);
      chk("ovf_set", 32'(smp_ovf), 32'd1);
      chk_lb("ovf_lb", 12'h100, 12'h101, 12'h102, 12'h103);
      idle(4);
      chk("ovf_sticky", 32'(smp_ovf), 32'd1);

      // Reset after the second read of a fetch.
      line(15'h0400);
      idle(2);
      d_we = n_lbwe; d_done = n_done;
      for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, acc);
      idle(3);
      chk("rstmid_lbwe_cnt", 32'(n_lbwe - d_we), 32'd0);
      chk("rstmid_done_cnt", 32'(n_done - d_done), 32'd0);
      chk("rstmid_ovf", 32'(smp_ovf), 32'd0);
      d_we = n_lbwe; d_done = n_done;
      line(15'h0500);
      idle(6);
      chk("rstmid_new_lbwe", 32'(n_lbwe - d_we), 32'd4);
      chk("rstmid_new_done", 32'(n_done - d_done), 32'd1);
      chk_lb("rstmid_lb", 12'h500, 12'h501, 12'h502, 12'h503);

      // Back-to-back writes.
      n_acc = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b0, '0, 1'b1, 15'h1000 + AW'(i), 12'h800 + DW'(i), acc);
         if (acc) n_acc++;
      end
      chk("b2b_count", 32'(n_acc), 32'd8);
      idle(1);
      for (int i = 0; i < 8; i++) begin
         chk("b2b_mem", 32'(mem[15'h1000 + AW'(i)]), 32'h800 + 32'(i));
      end

      // Table of single-cycle port decisions taken from idle.
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, tbl[3'(i)].req, tbl[3'(i)].base, tbl[3'(i)].wv, tbl[3'(i)].wa,
               tbl[3'(i)].wd, acc);
         chk("tbl_ready", 32'(smp_ready), 32'(tbl[3'(i)].e_ready));
         chk("tbl_we", 32'(smp_we), 32'(tbl[3'(i)].e_we));
         chk("tbl_addr", 32'(smp_addr), 32'(tbl[3'(i)].e_addr));
         idle(L + 3);
      end

      // Random traffic; the writer holds each word until it is taken.
      hold = 1'b0;
      ha = '0;
      hd = '0;
      rst_left = 0;
      for (int n = 0; n < 3000; n++) begin
         rst_v = 1'b1;
         if (rst_left > 0) begin
            rst_v = 1'b0;
            rst_left--;
         end else if ($urandom_range(0, 599) == 0) begin
            rst_v = 1'b0;
            rst_left = 1;
         end
         if (!hold && $urandom_range(0, 1) == 1) begin
            hold = 1'b1;
            ha = AW'($urandom);
            hd = DW'($urandom);
         end
         cycle(rst_v, ($urandom_range(0, 15) == 0), AW'($urandom), hold, ha, hd, acc);
         if (acc) hold = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
